taylor_out_collector: RTL and testbench
=======================================

Name: taylor_out_collector

Overview:
Downstream of the rede_taylor processor core. Captures each 28-bit signed result written to output port k, where k is 0..3. A write is marked by the one-hot strobe out_en[k] with io_out valid in the same cycle.
Results are buffered in per-port FIFOs and re-emitted as a single valid/ready stream tagged with the port index, so the consumer never has to keep pace with the processor.
Reports per-port overflow and multi-hot strobe errors.

Parameters:
NCH, 4, number of processor output ports; must equal the out_en width
DW, 28, result width (1 sign + 8 exponent + 19 mantissa, after float2int)
DEPTH, 8, entries per channel FIFO; power of two, at least 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
io_out  in  DW  signed result from processor, valid when any out_en bit is high
out_en  in  NCH  one-hot write strobe per output port
m_data  out  DW  buffered result
m_chan  out  clog2(NCH)  port index of m_data
m_valid  out  1  m_data/m_chan valid
m_ready  in  1  consumer accepts when m_valid and m_ready are both high
ovf  out  NCH  sticky: a sample for that port was dropped
err_multi  out  1  sticky: out_en seen with more than one bit set
ovf_clr  in  1  clears ovf and err_multi (one-cycle pulse)

Behaviour:
- Reset, synchronous, active-high:
  - m_valid=0, m_data=0, m_chan=0, ovf=0, err_multi=0.
  - All FIFOs empty; arbiter pointer=0.
  - Reset mid-transfer discards all buffered data.
- Capture:
  - On the edge where out_en[k]=1, io_out is pushed into FIFO k.
  - Multi-hot out_en: only the lowest set index is captured; err_multi is set.
- Full FIFO:
  - A push is dropped and ovf[k] is set when FIFO k holds DEPTH entries and is not popped in the same cycle.
  - A push is accepted when the same cycle also pops that FIFO.
- Output register, one stage:
  - Loads when it is empty or being accepted this cycle (m_valid=0, or m_valid&&m_ready).
  - Source is the next non-empty FIFO in round-robin order, starting at pointer+1 after the last served channel.
  - The pointer advances only on a load.
- Stability: while m_valid=1 and m_ready=0, m_data and m_chan hold stable. No bubble is inserted while data is available, so the sustained rate is one sample per cycle.
- Latency:
  - out_en at cycle N puts the sample in the FIFO after edge N.
  - m_valid is high in cycle N+2 when the FIFO was empty and the output register free.
- Bypass: none; the FIFO is always traversed.
- Ordering: per-channel order is preserved; cross-channel order is round-robin, not arrival order.
- ovf_clr:
  - Clears ovf and err_multi.
  - If a new overflow occurs in the same cycle as ovf_clr, the set wins.
- Arithmetic: data is passed unmodified (no sign handling). FIFO pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.

Optional Feature:
Macro TAYLOR_OUT_TSTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping at 65535.
  - The counter value is stored alongside each sample at capture.
  - New output port m_tstamp[15:0] is aligned with m_data.
- Undefined: no counter, no extra FIFO width, no m_tstamp port.

Decomposition:
- Package taylor_io_pkg holds:
  - NCH=4, DW=28, CHW=clog2(NCH)
  - Typedef sample_t (signed DW)
  - Typedef chan_t
  - Typedef entry_t (sample_t plus optional tstamp)
- Sub-module taylor_sync_fifo: single-clock, synchronous-reset FIFO with push/pop/full/empty/count. It is instantiated NCH times.
- Arbiter and output register live in the top.

Test Plan:
- Reset then idle: out_en=0 for 20 cycles -> m_valid=0, ovf=0, err_multi=0 throughout.
- Single sample, latency: m_ready=1; at cycle 5 drive io_out=28'sh8000123, out_en=4'b0100 -> cycle 7 shows m_valid=1, m_data=28'sh8000123, m_chan=2; m_valid=0 at cycle 8.
- Round-robin: m_ready=0; push A0 on ch0, B0 on ch1, C0 on ch3; then m_ready=1 -> output order A0(0), B0(1), C0(3), one per cycle.
- Backpressure and overflow:
  - m_ready=0; push 10 samples to ch1 (DEPTH=8).
  - One sits in the output register, 8 are in the FIFO, and the 10th is dropped, so ovf=4'b0010.
  - Release m_ready -> values 1..9 are emitted in order.
  - ovf_clr pulse -> ovf=0.
- Multi-hot: out_en=4'b1010, io_out=100 -> captured on ch1 only; err_multi=1.
- Reset mid-stream: 3 samples buffered, m_valid=1; assert rst one cycle -> next cycle m_valid=0, and nothing emits afterwards until a new push.

Source files
------------

// File: rtl/taylor_io_pkg.sv
// Shared types for the rede_taylor output collector.
// With TAYLOR_OUT_TSTAMP_EN defined, each buffered entry also carries a 16-bit capture timestamp.
package taylor_io_pkg;

  localparam int NCH = 4;
  localparam int DW  = 28;
  localparam int CHW = $clog2(NCH);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic [CHW-1:0]       chan_t;

  typedef struct packed {
`ifdef TAYLOR_OUT_TSTAMP_EN
    logic [15:0] tstamp;
`endif
    sample_t     data;
  } entry_t;

  // Index of the lowest set strobe bit; callers only use it when some bit is set.
  function automatic chan_t lowest_set(input logic [NCH-1:0] v);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = chan_t'(i);
    end
  endfunction

endpackage

// File: rtl/taylor_out_collector_if.sv
// Tagged valid/ready result stream from the collector to its consumer.
// With TAYLOR_OUT_TSTAMP_EN defined, the stream also carries m_tstamp aligned with m_data.
interface taylor_out_collector_if;
  import taylor_io_pkg::*;

  sample_t     m_data;
  chan_t       m_chan;
  logic        m_valid;
  logic        m_ready;
`ifdef TAYLOR_OUT_TSTAMP_EN
  logic [15:0] m_tstamp;

  modport master (output m_data, m_chan, m_valid, m_tstamp, input m_ready);
  modport slave  (input m_data, m_chan, m_valid, m_tstamp, output m_ready);
`else
  modport master (output m_data, m_chan, m_valid, input m_ready);
  modport slave  (input m_data, m_chan, m_valid, output m_ready);
`endif

endinterface

// File: rtl/taylor_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and first-word-fall-through read.
// A push into a full FIFO is accepted only when the same cycle also pops.
module taylor_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/taylor_out_collector.sv
// Buffers rede_taylor port writes in per-port FIFOs and re-emits them as one round-robin tagged stream.
// Optional TAYLOR_OUT_TSTAMP_EN: free-running 16-bit capture timestamp travels with each sample.
module taylor_out_collector
  import taylor_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  sample_t                io_out,
  input  logic [NCH-1:0]         out_en,
  input  logic                   ovf_clr,
  output logic [NCH-1:0]         ovf,
  output logic                   err_multi,
  taylor_out_collector_if.master m
);

  localparam int CW = $clog2(DEPTH) + 1;

  entry_t         in_entry;
  entry_t         fifo_dout  [NCH];
  logic [CW-1:0]  fifo_count [NCH];
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] ovf_new;
  logic           multi;
  logic           load;
  logic           grant_vld;
  chan_t          grant;
  chan_t          cand;
  chan_t          ptr_q;

`ifdef TAYLOR_OUT_TSTAMP_EN
  logic [15:0] tstamp_q;

  always_ff @(posedge clk) begin
    if (rst) tstamp_q <= '0;
    else     tstamp_q <= tstamp_q + 1'b1;
  end
`endif

  // Multi-hot strobes keep only the lowest port.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    push = '0;
    if (out_en != '0) push[lowest_set(out_en)] = 1'b1;
  end

  assign multi = (out_en & (out_en - 1'b1)) != '0;

  always_comb begin
    in_entry      = '0;
    in_entry.data = io_out;
`ifdef TAYLOR_OUT_TSTAMP_EN
    in_entry.tstamp = tstamp_q;
`endif
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    taylor_sync_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .din   (in_entry),
      .pop   (pop[k]),
      .dout  (fifo_dout[k]),
      .full  (full[k]),
      .empty (empty[k]),
      .count (fifo_count[k])
    );

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
      fifo_count[k] <= CW'(DEPTH));
  end

  // Round-robin search starts one past the last served channel.
  assign load = !m.m_valid || m.m_ready;

  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = chan_t'((int'(ptr_q) + i) % NCH);
      if (!grant_vld && !empty[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_vld) pop[grant] = 1'b1;
  end

  // A push into a full FIFO is lost unless that FIFO is popped in the same cycle.
  assign ovf_new = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_chan  <= '0;
`ifdef TAYLOR_OUT_TSTAMP_EN
      m.m_tstamp <= '0;
`endif
      ptr_q     <= '0;
      ovf       <= '0;
      err_multi <= 1'b0;
    end else begin
      if (load) begin
        m.m_valid <= grant_vld;
        if (grant_vld) begin
          m.m_data <= fifo_dout[grant].data;
          m.m_chan <= grant;
`ifdef TAYLOR_OUT_TSTAMP_EN
          m.m_tstamp <= fifo_dout[grant].tstamp;
`endif
          ptr_q    <= grant;
        end
      end
      // A new error in the clear cycle survives the clear.
      ovf       <= (ovf_clr ? '0 : ovf) | ovf_new;
      err_multi <= (ovf_clr ? 1'b0 : err_multi) | multi;
    end
  end

endmodule

// File: tb/tb_taylor_out_collector.sv
// Self-checking bench for taylor_out_collector: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_taylor_out_collector;
  import taylor_io_pkg::*;

  localparam int DEPTH = 8;

  logic           clk     = 1'b0;
  logic           rst     = 1'b1;
  sample_t        io_out  = '0;
  logic [NCH-1:0] out_en  = '0;
  logic           ovf_clr = 1'b0;
  logic [NCH-1:0] ovf;
  logic           err_multi;
  logic           cmp_en  = 1'b0;

  taylor_out_collector_if m_if ();

  taylor_out_collector #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_out    (io_out),
    .out_en    (out_en),
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
    .err_multi (err_multi),
    .m         (m_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-port queues plus one output slot ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [15:0]   ts;
  } ment_t;

  ment_t          mq [NCH][$];
  logic           mv;
  logic [DW-1:0]  md;
  logic [15:0]    mts;
  int             mc;
  int             mptr;
  logic [NCH-1:0] movf;
  logic           merr;
  logic [15:0]    mcnt;

  task automatic model_step();
    logic [NCH-1:0] nov;
    int             pick;
    int             c;
    int             k;
    ment_t          e;
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) mq[ch].delete();
      mv = 1'b0; md = '0; mts = '0; mc = 0; mptr = 0;
      movf = '0; merr = 1'b0; mcnt = '0;
    end else begin
      if (!mv || m_if.m_ready) begin
        pick = -1;
        for (int i = 1; i <= NCH; i++) begin
          c = (mptr + i) % NCH;
          if (pick < 0 && mq[c].size() > 0) pick = c;
        end
        if (pick >= 0) begin
          e    = mq[pick].pop_front();
          mv   = 1'b1;
          md   = e.d;
          mts  = e.ts;
          mc   = pick;
          mptr = pick;
        end else begin
          mv = 1'b0;
        end
      end
      nov = '0;
      if (out_en != '0) begin
        k = 0;
        while (!out_en[k]) k++;
        if (mq[k].size() == DEPTH) nov[k] = 1'b1;
        else mq[k].push_back('{d: io_out, ts: mcnt});
      end
      movf = (ovf_clr ? '0 : movf) | nov;
      merr = (ovf_clr ? 1'b0 : merr) | ($countones(out_en) > 1);
      mcnt = mcnt + 16'd1;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", 64'(m_if.m_valid), 64'(mv));
      if (mv) begin
        check("m_data", {36'd0, m_if.m_data}, {36'd0, md});
        check("m_chan", 64'(m_if.m_chan), 64'(mc));
`ifdef TAYLOR_OUT_TSTAMP_EN
        check("m_tstamp", 64'(m_if.m_tstamp), 64'(mts));
`endif
      end
      check("ovf", 64'(ovf), 64'(movf));
      check("err_multi", 64'(err_multi), 64'(merr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int ch, input logic [DW-1:0] v);
    out_en = NCH'(1) << ch;
    io_out = v;
    tick();
    out_en = '0;
  endtask

  int ready_pct;

  initial begin
    m_if.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset.
    repeat (20) begin
      @(negedge clk);
      check("idle_valid", 64'(m_if.m_valid), 64'd0);
      check("idle_ovf", 64'(ovf), 64'd0);
      check("idle_err", 64'(err_multi), 64'd0);
    end

    // Single sample: visible two cycles after the strobe, gone the cycle after.
    tick();
    push_one(2, 28'h8000123);
    tick();
    @(negedge clk);
    check("lat_valid", 64'(m_if.m_valid), 64'd1);
    check("lat_data", {36'd0, m_if.m_data}, 64'h8000123);
    check("lat_chan", 64'(m_if.m_chan), 64'd2);
    tick();
    @(negedge clk);
    check("lat_valid_off", 64'(m_if.m_valid), 64'd0);

    // Round robin across ch0, ch1, ch3.
    tick();
    m_if.m_ready = 1'b0;
    push_one(0, 28'h00000A0);
    push_one(1, 28'h00000B0);
    push_one(3, 28'h00000C0);
    tick();
    tick();
    m_if.m_ready = 1'b1;
    @(negedge clk);
    check("rr0_data", {36'd0, m_if.m_data}, 64'hA0);
    check("rr0_chan", 64'(m_if.m_chan), 64'd0);
    tick();
    @(negedge clk);
    check("rr1_data", {36'd0, m_if.m_data}, 64'hB0);
    check("rr1_chan", 64'(m_if.m_chan), 64'd1);
    tick();
    @(negedge clk);
    check("rr2_data", {36'd0, m_if.m_data}, 64'hC0);
    check("rr2_chan", 64'(m_if.m_chan), 64'd3);
    tick();
    @(negedge clk);
    check("rr_drained", 64'(m_if.m_valid), 64'd0);

    // Backpressure and overflow on ch1: 1 in register, 8 in FIFO, the 10th dropped.
    tick();
    m_if.m_ready = 1'b0;
    for (int v = 1; v <= 10; v++) push_one(1, DW'(v));
    tick();
    @(negedge clk);
    check("ovf_set", 64'(ovf), 64'h2);
    check("ovf_hold_data", {36'd0, m_if.m_data}, 64'd1);
    tick();
    m_if.m_ready = 1'b1;
    for (int v = 1; v <= 9; v++) begin
      @(negedge clk);
      check("ovf_drain_data", {36'd0, m_if.m_data}, 64'(v));
      check("ovf_drain_chan", 64'(m_if.m_chan), 64'd1);
      tick();
    end
    @(negedge clk);
    check("ovf_drained", 64'(m_if.m_valid), 64'd0);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 64'(ovf), 64'd0);

    // Multi-hot strobe: only ch1 captures.
    tick();
    out_en = 4'b1010;
    io_out = 28'd100;
    tick();
    out_en = '0;
    tick();
    @(negedge clk);
    check("multi_valid", 64'(m_if.m_valid), 64'd1);
    check("multi_data", {36'd0, m_if.m_data}, 64'd100);
    check("multi_chan", 64'(m_if.m_chan), 64'd1);
    check("multi_err", 64'(err_multi), 64'd1);
    tick();
    @(negedge clk);
    check("multi_single", 64'(m_if.m_valid), 64'd0);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err_multi), 64'd0);

    // Reset with buffered data discards everything.
    tick();
    m_if.m_ready = 1'b0;
    push_one(0, 28'd11);
    push_one(2, 28'd22);
    push_one(3, 28'd33);
    tick();
    @(negedge clk);
    check("pre_rst_valid", 64'(m_if.m_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(m_if.m_valid), 64'd0);
    tick();
    m_if.m_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(m_if.m_valid), 64'd0);
      tick();
    end

    // Randomized traffic with varying consumer throughput.
    ready_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       ready_pct = 10;
          1:       ready_pct = 50;
          default: ready_pct = 95;
        endcase
      end
      io_out = sample_t'($urandom);
      case ($urandom_range(0, 99)) inside
        [0:49]:  out_en = NCH'(1) << $urandom_range(0, NCH - 1);
        [50:55]: out_en = NCH'($urandom);
        default: out_en = '0;
      endcase
      m_if.m_ready = ($urandom_range(0, 99) < ready_pct);
      ovf_clr      = ($urandom_range(0, 63) == 0);
      rst          = ($urandom_range(0, 1499) == 0);
      tick();
    end
    out_en       = '0;
    ovf_clr      = 1'b0;
    rst          = 1'b0;
    m_if.m_ready = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
